// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: port ids, arbiter states and data-memory widths shared with the datapath
package dm_arb_pkg;
   localparam int DM_DATA_W = 19;
   localparam int DM_ADDR_W = 8;
   typedef enum logic {PORT_CPU = 1'b0, PORT_LD = 1'b1} portId_t;
   typedef enum logic {ARB = 1'b0, LD_BURST = 1'b1} arbState_t;
endpackage

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin share of the data memory between the CPU and the loader, with loader burst lock
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int DATA_W = DM_DATA_W,
   parameter int ADDR_W = DM_ADDR_W,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              en,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   input  logic              ld_lock,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic [DATA_W-1:0] dm_rdata
);
   arbState_t state, stateNext;
   portId_t last, lastNext, rdOwner;
   logic [3:0] burstCnt, burstCntNext;
   logic rvalidQ;
   logic burstOn, cntFull;
   // a burst only holds while the loader keeps ld_lock asserted
   assign burstOn = (state == LD_BURST) & ld_lock;
   assign cntFull = burstCnt == 4'(MAX_BURST);
   assign cpu_stall = cpu_req & ~cpu_gnt;
   assign cpu_rvalid = en & rvalidQ & (rdOwner == PORT_CPU);
   assign ld_rvalid = en & rvalidQ & (rdOwner == PORT_LD);
   assign rdata = dm_rdata;
   // state register; reset leaves last=LD so the CPU wins the first tie
   always_ff @(posedge clk) begin
      if (!en) begin
         state <= ARB;
         last <= PORT_LD;
         burstCnt <= '0;
         rvalidQ <= 1'b0;
         rdOwner <= PORT_CPU;
      end else begin
         state <= stateNext;
         last <= lastNext;
         burstCnt <= burstCntNext;
         rvalidQ <= (cpu_gnt & ~cpu_we) | (ld_gnt & ~ld_we);
         rdOwner <= ld_gnt ? PORT_LD : PORT_CPU;
      end
   end
   // next state: a locked loader grant opens a burst, dropping the lock closes it with last=LD
   always_comb begin
      stateNext = (ld_gnt & ld_lock) ? LD_BURST : ARB;
      burstCntNext = {3'b000, ld_gnt & ld_lock};
      lastNext = (state == LD_BURST) ? PORT_LD : cpu_gnt ? PORT_CPU : ld_gnt ? PORT_LD : last;
      if (burstOn) begin
         stateNext = LD_BURST;
         lastNext = last;
         burstCntNext = (cpu_gnt & cntFull) ? 4'd0 : (ld_gnt & ~cntFull) ? burstCnt + 4'd1 : burstCnt;
      end
   end
   // grant selection and memory-port mux from the granted requester
   always_comb begin
      cpu_gnt = 1'b0;
      if (en)
         cpu_gnt = burstOn ? cpu_req & (cntFull | ~ld_req) : cpu_req & (~ld_req | last == PORT_LD);
      ld_gnt = en & ld_req & ~cpu_gnt;
      dm_we = cpu_gnt ? cpu_we : ld_gnt & ld_we;
      dm_addr = cpu_gnt ? cpu_addr : ld_gnt ? ld_addr : '0;
      dm_wdata = cpu_gnt ? cpu_wdata : ld_gnt ? ld_wdata : '0;
   end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU datapath (port 0) and the program/data loader (port 1).
- Sits between the controller/datapath and the data memory. It replaces the direct datapath-to-memory connection.
- Uses round-robin arbitration. The loader may lock the memory for a burst, but the CPU is guaranteed a slot every MAX_BURST loader accesses.
- The controller stalls on cpu_stall until its access is granted.

Parameters:
- DATA_W, 19, data word width.
- ADDR_W, 8, data-memory address width.
- MAX_BURST, 4, loader grants allowed during a lock before a pending CPU request is forced through (range 1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- en  in  1  synchronous active-low reset (en==0 resets at the clock edge).
- cpu_req  in  1  CPU access request; held high until cpu_gnt.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU access issued this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- cpu_rvalid  out  1  CPU read data valid on rdata.
- ld_req  in  1  loader request; held until ld_gnt.
- ld_we  in  1  loader write/read.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_lock  in  1  loader burst lock request.
- ld_gnt  out  1  loader access issued this cycle.
- ld_rvalid  out  1  loader read data valid on rdata.
- rdata  out  DATA_W  read data, broadcast to both ports (equals dm_rdata).
- dm_we  out  1  memory write enable.
- dm_addr  out  ADDR_W  memory address.
- dm_wdata  out  DATA_W  memory write data.
- dm_rdata  in  DATA_W  memory read data; 1-cycle latency after address.

Behaviour:
- Timing:
  - Grant is combinational from the current requests plus registered state.
  - dm_addr, dm_we and dm_wdata are muxed from the granted port in the same cycle as the grant.
  - A write commits at the edge that ends the grant cycle.
  - A read returns on the next cycle: rvalid_q <= granted & ~we, and rd_owner is registered. cpu_rvalid = rvalid_q & (rd_owner==CPU); ld_rvalid is the mirror.
- At most one grant per cycle; throughput is 1 access per cycle.
- No grant: dm_we=0, dm_addr=0, dm_wdata=0.
- Registered state: state {ARB, LD_BURST}, last (last granted port), burst_cnt[3:0], rvalid_q, rd_owner.
- Reset (en==0):
  - At the edge: state=ARB, last=LD (so the CPU wins the first tie), burst_cnt=0, rvalid_q=0.
  - While en==0, all grants, rvalids and dm_we are forced to 0 combinationally.
  - A reset mid-burst drops any pending rvalid.
- ARB state:
  - Single request: grant that port.
  - Both requests: grant the port != last.
  - last updates on every grant.
  - If ld_gnt & ld_lock: go to LD_BURST, burst_cnt=1.
  - ld_lock without ld_req is ignored.
- LD_BURST state:
  - ld_lock==0 at the start of the cycle: the cycle is arbitrated as in ARB; state->ARB, burst_cnt=0.
  - Otherwise, if cpu_req & burst_cnt==MAX_BURST: grant CPU; burst_cnt=0.
  - Otherwise, if ld_req: grant loader; burst_cnt increments, saturating at MAX_BURST.
  - Otherwise, if cpu_req: grant CPU in the idle slot; burst_cnt unchanged.
  - last is not updated during LD_BURST; on exit, last=LD.
- Requester rules:
  - A requester must hold req, we, addr and wdata stable until its grant.
  - Changing them before the grant is a protocol violation; behaviour is unspecified.
  - A grant is a single-cycle pulse per accepted access. A back-to-back request may be granted again the next cycle.

Decomposition:
- Shared package dm_arb_pkg:
  - Port IDs PORT_CPU=0, PORT_LD=1.
  - State encodings ARB, LD_BURST.
  - Default widths for DATA_W and ADDR_W, shared with the datapath.
- No sub-module required. A single always-block FSM plus an output mux suffices; optionally factor rr_pick (2-way round-robin select) as a sub-module.

Test Plan:
- Only the CPU reads addr 0x05 (memory holds 0x1ABCD) -> cpu_gnt the same cycle; cpu_rvalid with rdata=0x1ABCD the next cycle; ld_rvalid=0.
- Both ports request every cycle, no lock, after reset -> grants alternate CPU, LD, CPU, LD; the first grant goes to the CPU.
- Loader locks and issues 10 writes while the CPU reads continuously, MAX_BURST=4 -> grant pattern LD×4, CPU, LD×4, CPU, LD×2. cpu_stall is high on all non-CPU-grant cycles.
- Loader writes 0x00055 to addr 0x10, then the CPU reads 0x10 the next cycle -> CPU rdata=0x00055 (write-before-read ordering).
- en driven low during LD_BURST, in the cycle after a loader read grant -> ld_rvalid=0; the next cycle after en returns high is in ARB, and a simultaneous request is granted to the CPU.
- ld_lock high with ld_req low, CPU requesting -> CPU granted every cycle; state stays ARB.
